// File: rtl/lfsr_cipher_pkg.sv
// Purpose: shared parameters, tap-pattern table, run configuration payload,
//          FSM state type and LFSR helper functions for the LFSR stream cipher.
// Ports:   none (package).
package lfsr_cipher_pkg;

    localparam int unsigned LW    = 7;            // LFSR / payload width
    localparam int unsigned DW    = LW + 1;       // stream byte width, MSB = parity
    localparam int unsigned LENW  = 6;            // message length width
    localparam int unsigned NPTRN = 9;            // candidate tap patterns
    localparam int unsigned PIW   = 4;            // pattern index width
    localparam int unsigned PROBE = 8;            // preamble bytes used for auto-detect
    localparam int unsigned PRW   = $clog2(PROBE);

    localparam logic [DW-1:0] PAD = 8'h20;

    localparam logic [LW-1:0] PTRN [NPTRN] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    // Run configuration latched on Start
    typedef struct packed {
        logic            mode;       // 0 = encrypt, 1 = decrypt
        logic            auto_en;    // decrypt only: auto-detect pattern/state
        logic [PIW-1:0]  ptrn_sel;
        logic [LW-1:0]   lfsr_init;
        logic [LENW-1:0] len;
    } cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_SEARCH,
        ST_REPLAY,
        ST_STREAM,
        ST_DONE
    } state_t;

    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s,
                                                input logic [LW-1:0] taps);
        return {s[LW-2:0], ^(s & taps)};
    endfunction

    function automatic logic parity(input logic [DW-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/lfsr_stream_cipher_if.sv
// Purpose: control / byte-stream handshake bundle of the LFSR stream cipher.
// Signals: start, cfg (run config), in_valid/in_data/in_ready (input stream),
//          out_valid/out_data/out_ready (output stream), ack, parity_err,
//          ptrn_miss, ptrn_idx (status).
// Modports: master = DMA/controller side, slave = cipher engine.
interface lfsr_stream_cipher_if;
    import lfsr_cipher_pkg::*;

    logic            start;
    cfg_t            cfg;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic            ack;
    logic            parity_err;
    logic            ptrn_miss;
    logic [PIW-1:0]  ptrn_idx;

    modport master (
        output start, cfg, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, ack, parity_err, ptrn_miss, ptrn_idx
    );

    modport slave (
        input  start, cfg, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, ack, parity_err, ptrn_miss, ptrn_idx
    );

endinterface

// File: rtl/lfsr_ptrn_probe.sv
// Purpose: preamble buffer plus a single-candidate tap-pattern comparator.
// Ports:   i_clk; i_wr_en/i_wr_idx/i_wr_data write one preamble byte;
//          i_rd_idx/o_rd_data_c read a buffered byte for replay;
//          i_taps candidate pattern; o_s0_c recovered start state;
//          o_match_c candidate explains every buffered state transition.
module lfsr_ptrn_probe
    import lfsr_cipher_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_wr_en,
    input  logic [PRW-1:0]  i_wr_idx,
    input  logic [DW-1:0]   i_wr_data,
    input  logic [PRW-1:0]  i_rd_idx,
    input  logic [LW-1:0]   i_taps,
    output logic [DW-1:0]   o_rd_data_c,
    output logic [LW-1:0]   o_s0_c,
    output logic            o_match_c
);

    logic [DW-1:0] r_buf [PROBE];
    logic [LW-1:0] w_s   [PROBE];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_buf[i_wr_idx] <= i_wr_data;
        end
    end

    // A pad byte encrypts to pad ^ state, so xoring the pad back recovers the state
    always_comb begin
        for (int i = 0; i < int'(PROBE); i++) begin
            w_s[i] = r_buf[i][LW-1:0] ^ PAD[LW-1:0];
        end
    end

    always_comb begin
        o_match_c = 1'b1;
        for (int i = 0; i < int'(PROBE) - 1; i++) begin
            if (w_s[i+1] != lfsr_step(w_s[i], i_taps)) begin
                o_match_c = 1'b0;
            end
        end
    end

    assign o_s0_c      = w_s[0];
    assign o_rd_data_c = r_buf[i_rd_idx];

endmodule

// File: rtl/lfsr_stream_cipher.sv
// Purpose: byte-serial LFSR encrypt/decrypt engine with parity MSB and
//          preamble-based auto-detection of tap pattern and start state.
// Ports:   i_clk, i_reset (synchronous, active-high);
//          io_bus (slave modport): start/cfg control, in_* and out_* valid/ready
//          byte streams, ack/parity_err/ptrn_miss/ptrn_idx status.
module lfsr_stream_cipher
    import lfsr_cipher_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    lfsr_stream_cipher_if.slave  io_bus
);

    state_t          r_state, w_state_nxt;
    logic            r_mode;
    logic [LENW-1:0] r_len, r_cnt, r_in_cnt;
    logic [LW-1:0]   r_lfsr;
    logic [PIW-1:0]  r_ptrn_idx, r_k;
    logic [PRW-1:0]  r_rp;
    logic            r_out_valid, r_ack, r_parity_err, r_ptrn_miss;
    logic [DW-1:0]   r_out_data;

    cfg_t            w_cfg;
    logic            w_start, w_auto_go, w_last_k;
    logic [PIW-1:0]  w_sel;
    logic [LW-1:0]   w_init, w_taps, w_cand, w_key, w_plain, w_s0;
    logic            w_out_hs, w_out_free, w_in_ready, w_in_fire, w_load, w_match;
    logic [DW-1:0]   w_src, w_buf_data, w_out_byte;

    assign w_cfg     = io_bus.cfg;
    assign w_start   = io_bus.start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_auto_go = w_cfg.mode & w_cfg.auto_en & (w_cfg.len >= LENW'(PROBE));
    assign w_sel     = (w_cfg.ptrn_sel < PIW'(NPTRN)) ? w_cfg.ptrn_sel : '0;
    assign w_init    = (w_cfg.lfsr_init == '0) ? LW'(1) : w_cfg.lfsr_init;
    assign w_last_k  = (r_k == PIW'(NPTRN - 1));

    assign w_taps     = PTRN[r_ptrn_idx];
    assign w_cand     = PTRN[r_k];
    assign w_out_hs   = r_out_valid & io_bus.out_ready;
    assign w_out_free = ~r_out_valid | io_bus.out_ready;
    assign w_in_fire  = w_in_ready & io_bus.in_valid;

    // A byte loaded in the same cycle as an output handshake sees the advanced state
    assign w_key      = w_out_hs ? lfsr_step(r_lfsr, w_taps) : r_lfsr;
    assign w_src      = (r_state == ST_REPLAY) ? w_buf_data : io_bus.in_data;
    assign w_plain    = w_src[LW-1:0] ^ w_key;
    assign w_out_byte = r_mode ? {1'b0, w_plain} : {parity({1'b0, w_plain}), w_plain};

    lfsr_ptrn_probe u_probe (
        .i_clk       (i_clk),
        .i_wr_en     ((r_state == ST_PROBE) & w_in_fire),
        .i_wr_idx    (r_in_cnt[PRW-1:0]),
        .i_wr_data   (io_bus.in_data),
        .i_rd_idx    (r_rp),
        .i_taps      (w_cand),
        .o_rd_data_c (w_buf_data),
        .o_s0_c      (w_s0),
        .o_match_c   (w_match)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, input acceptance and output-register load
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    if (w_cfg.len == '0) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_auto_go) begin
                        w_state_nxt = ST_PROBE;
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end
            end
            ST_PROBE: begin
                w_in_ready = 1'b1;
                if (io_bus.in_valid && (r_in_cnt == LENW'(PROBE - 1))) begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (w_match || w_last_k) begin
                    w_state_nxt = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                w_load = w_out_free;
                if (w_out_free && (r_rp == PRW'(PROBE - 1))) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_in_ready = (r_in_cnt != r_len) & w_out_free;
                w_load     = w_in_ready & io_bus.in_valid;
                if (w_out_hs && ((r_cnt + LENW'(1)) == r_len)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath, counters and status registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode       <= 1'b0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_in_cnt     <= '0;
            r_lfsr       <= LW'(1);
            r_ptrn_idx   <= '0;
            r_k          <= '0;
            r_rp         <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_ack        <= 1'b0;
            r_parity_err <= 1'b0;
            r_ptrn_miss  <= 1'b0;
        end else begin
            r_ack <= (w_state_nxt == ST_DONE);
            if (w_start) begin
                r_mode       <= w_cfg.mode;
                r_len        <= w_cfg.len;
                r_lfsr       <= w_init;
                r_ptrn_idx   <= w_sel;
                r_ptrn_miss  <= w_cfg.mode & w_cfg.auto_en & (w_cfg.len != '0) & ~w_auto_go;
                r_parity_err <= 1'b0;
                r_cnt        <= '0;
                r_in_cnt     <= '0;
                r_k          <= '0;
                r_rp         <= '0;
            end else begin
                if (w_in_fire) begin
                    r_in_cnt <= r_in_cnt + LENW'(1);
                end
                // Lowest matching candidate wins; otherwise keep the manual setup
                if (r_state == ST_SEARCH) begin
                    if (w_match) begin
                        r_ptrn_idx <= r_k;
                        r_lfsr     <= w_s0;
                    end else if (w_last_k) begin
                        r_ptrn_miss <= 1'b1;
                    end else begin
                        r_k <= r_k + PIW'(1);
                    end
                end
                if (w_out_hs) begin
                    r_cnt  <= r_cnt + LENW'(1);
                    r_lfsr <= lfsr_step(r_lfsr, w_taps);
                end
                if ((r_state == ST_REPLAY) && w_out_free) begin
                    r_rp <= r_rp + PRW'(1);
                end
                if (w_load) begin
                    r_out_data <= w_out_byte;
                    if (r_mode && parity(w_src)) begin
                        r_parity_err <= 1'b1;
                    end
                end
                if (w_load) begin
                    r_out_valid <= 1'b1;
                end else if (w_out_hs) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.out_valid  = r_out_valid;
    assign io_bus.out_data   = r_out_data;
    assign io_bus.ack        = r_ack;
    assign io_bus.parity_err = r_parity_err;
    assign io_bus.ptrn_miss  = r_ptrn_miss;
    assign io_bus.ptrn_idx   = r_ptrn_idx;

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Purpose: scoreboard bench for lfsr_stream_cipher: directed runs push the
//          expected output bytes, an independent monitor pops and compares.
module tb_lfsr_stream_cipher;
    import lfsr_cipher_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_stream_cipher_if bus();

    lfsr_stream_cipher dut (
        .i_clk   (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_hs_cyc = 0;
    bit          stall    = 1'b0;
    logic [7:0]  exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer side: optional random back-pressure, changed just after each edge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: a handshake seen here completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got %02h with empty scoreboard", bus.out_data);
            end else begin
                chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic start_run(input bit mode, input bit auto_en, input logic [3:0] sel,
                             input logic [6:0] init, input logic [5:0] len);
        cfg_t c;
        c.mode      = mode;
        c.auto_en   = auto_en;
        c.ptrn_sel  = sel;
        c.lfsr_init = init;
        c.len       = len;
        bus.cfg     = c;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        int budget = 0;
        if (stall) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready || budget > 300) break;
            budget++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_accept: byte %02h not accepted within budget", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ack(input string tag, output int acyc);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.ack) break;
        end
        acyc = cyc;
        chk({tag, "_ack"}, 32'(bus.ack), 32'd1);
    endtask

    task automatic run(input string tag, input bit mode, input bit auto_en,
                       input logic [3:0] sel, input logic [6:0] init,
                       input logic [7:0] din[$], input logic [7:0] dexp[$],
                       input bit e_perr, input bit e_miss, input logic [3:0] e_idx,
                       output int acyc);
        foreach (dexp[i]) exp_q.push_back(dexp[i]);
        start_run(mode, auto_en, sel, init, 6'(din.size()));
        foreach (din[i]) send(din[i]);
        wait_ack(tag, acyc);
        chk({tag, "_drain"},     32'(exp_q.size()),    32'd0);
        chk({tag, "_parity"},    32'(bus.parity_err),  32'(e_perr));
        chk({tag, "_ptrn_miss"}, 32'(bus.ptrn_miss),   32'(e_miss));
        chk({tag, "_ptrn_idx"},  32'(bus.ptrn_idx),    32'(e_idx));
        chk({tag, "_out_valid"}, 32'(bus.out_valid),   32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, "_out_data"},   32'(bus.out_data),   32'd0);
        chk({tag, "_ack"},        32'(bus.ack),        32'd0);
        chk({tag, "_parity"},     32'(bus.parity_err), 32'd0);
        chk({tag, "_ptrn_miss"},  32'(bus.ptrn_miss),  32'd0);
        chk({tag, "_ptrn_idx"},   32'(bus.ptrn_idx),   32'd0);
        chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
    endtask

    initial begin
        logic [7:0] din[$];
        logic [7:0] dexp[$];
        logic [7:0] cmsg[$];
        logic [7:0] pmsg[$];
        logic [6:0] s, p, c;
        int acyc;

        rst = 1'b1;
        bus.start    = 1'b0;
        bus.cfg      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Encrypt, pattern 0x60, init 0x01: keystream 01, 02
        din = {8'h20, 8'h20};
        dexp = {8'h21, 8'h22};
        run("enc", 1'b0, 1'b0, 4'd0, 7'h01, din, dexp, 1'b0, 1'b0, 4'd0, acyc);
        chk("enc_ack_timing", 32'(acyc), 32'(last_hs_cyc + 1));

        // Out-of-range selector and zero init fall back to pattern 0 / state 1
        run("enc_sanitize", 1'b0, 1'b0, 4'd15, 7'h00, din, dexp, 1'b0, 1'b0, 4'd0, acyc);

        // Decrypt the ciphertext back
        din = {8'h21, 8'h22};
        dexp = {8'h20, 8'h20};
        run("dec", 1'b1, 1'b0, 4'd0, 7'h01, din, dexp, 1'b0, 1'b0, 4'd0, acyc);

        // Bit 0 of byte 0 flipped: still emitted, parity error flagged
        din = {8'h20, 8'h22};
        dexp = {8'h21, 8'h20};
        run("dec_perr", 1'b1, 1'b0, 4'd0, 7'h01, din, dexp, 1'b1, 1'b0, 4'd0, acyc);

        // Auto with a message shorter than the probe window: miss, manual path
        din = {8'h21, 8'h22};
        dexp = {8'h20, 8'h20};
        run("auto_short", 1'b1, 1'b1, 4'd0, 7'h01, din, dexp, 1'b0, 1'b1, 4'd0, acyc);

        // 63-byte message (largest Len): 12 pad bytes then text, pattern 0x69, init 0x05.
        // Init 0x05 gives feedback 1 under 0x69 but 0 under patterns 0..4.
        s = 7'h05;
        for (int i = 0; i < 63; i++) begin
            p = (i < 12) ? 7'h20 : 7'(65 + (i - 12) % 26);
            c = p ^ s;
            cmsg.push_back({^c, c});
            pmsg.push_back({1'b0, p});
            s = {s[5:0], ^(s & 7'h69)};
        end
        run("auto", 1'b1, 1'b1, 4'd0, 7'h01, cmsg, pmsg, 1'b0, 1'b0, 4'd5, acyc);

        // Corrupted preamble byte 3: no pattern matches, manual pattern 5 / init 05
        din = cmsg;
        din[3] = din[3] ^ 8'h01;
        dexp = pmsg;
        dexp[3] = 8'h21;
        run("auto_miss", 1'b1, 1'b1, 4'd5, 7'h05, din, dexp, 1'b1, 1'b1, 4'd5, acyc);

        // Same auto message under random input and output stalls
        stall = 1'b1;
        run("auto_stall", 1'b1, 1'b1, 4'd0, 7'h01, cmsg, pmsg, 1'b0, 1'b0, 4'd5, acyc);
        stall = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of streaming, Start ignored while reset is high
        for (int i = 0; i < 20; i++) exp_q.push_back(pmsg[i]);
        start_run(1'b1, 1'b1, 4'd0, 7'h01, 6'd63);
        for (int i = 0; i < 20; i++) send(cmsg[i]);
        rst = 1'b1;
        start_run(1'b0, 1'b0, 4'd3, 7'h01, 6'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check_idle("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Len = 0: Ack the cycle after Start, never any output
        start_run(1'b0, 1'b0, 4'd0, 7'h01, 6'd0);
        @(negedge clk);
        chk("len0_ack", 32'(bus.ack), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("len0_out_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        chk("len0_ack_held", 32'(bus.ack), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
